// File: rtl/audio_frame_decimator.sv
// audio_frame_decimator
//   Keeps 1 of every DECIM microphone samples and packs the kept samples into
//   FRAME_LEN-sample frames in a two-bank (ping-pong) RAM. Each full bank is
//   streamed out over AXI-Stream in FFT complex format, with tlast on the
//   final word of the frame.
//
// Ports
//   clk_in         system clock (single clock domain)
//   rst_in         synchronous active-high reset
//   s_valid        one-cycle strobe marking a new input sample (no backpressure)
//   s_data         16-bit signed sample
//   m_axis_tvalid  output word valid
//   m_axis_tready  downstream (FFT) ready
//   m_axis_tdata   {16'h0000 imag, 16-bit real sample}
//   m_axis_tlast   last word of a frame
//   overflow       sticky: a kept sample was dropped because both banks were full
module audio_frame_decimator #(
  parameter int DECIM     = 8,
  parameter int FRAME_LEN = 256
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        overflow
);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [DW-1:0] DEC_MAX  = DW'(DECIM - 1);

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM} rd_state_t;

  logic [DW-1:0] dec_cnt;
  logic          wr_bank, rd_bank;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [1:0]    full;
  logic [15:0]   mem [2*FRAME_LEN];
  logic [15:0]   rd_q;
  logic [15:0]   out_data;
  rd_state_t     state, state_nxt;

  logic          keep, wr_en, wr_done, hs;
  logic          rd_en, load_out, advance, frame_done;
  logic [IW-1:0] rd_addr;

  assign keep    = s_valid && (dec_cnt == '0);
  assign wr_en   = keep && !full[wr_bank];
  assign wr_done = wr_en && (wr_idx == LAST_IDX);
  assign hs      = m_axis_tvalid && m_axis_tready;

  // ---------------- write side ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dec_cnt  <= '0;
      wr_bank  <= 1'b0;
      wr_idx   <= '0;
      overflow <= 1'b0;
    end else begin
      if (s_valid) dec_cnt <= (dec_cnt == DEC_MAX) ? '0 : dec_cnt + 1'b1;
      if (keep && full[wr_bank]) overflow <= 1'b1;
      if (wr_en) begin
        // FRAME_LEN is a power of two, so the index wraps to 0 on its own
        wr_idx <= wr_idx + 1'b1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank fill/drain flags. Set and clear always hit different banks: the
  // writer only completes a non-full bank, the reader only clears a full one.
  always_ff @(posedge clk_in) begin
    if (rst_in) full <= '0;
    else        full <= (full | ({1'b0, wr_done} << wr_bank))
                        & ~({1'b0, frame_done} << rd_bank);
  end

  // Simple dual-port RAM, registered read, no reset so it maps to block RAM.
  // rd_q only updates on rd_en, so it doubles as the one-entry prefetch that
  // holds word rd_idx+1 while the output register is stalled on word rd_idx.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= s_data;
    if (rd_en) rd_q <= mem[{rd_bank, rd_addr}];
  end

  // ---------------- read side ----------------
  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    rd_addr    = '0;
    load_out   = 1'b0;
    advance    = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          rd_en     = 1'b1;
          state_nxt = PREFETCH;
        end
      end
      PREFETCH: begin
        // word 0 moves to the output, word 1 is fetched behind it
        rd_en     = 1'b1;
        rd_addr   = IW'(1);
        load_out  = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (hs) begin
          if (rd_idx == LAST_IDX) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end else begin
            rd_en    = 1'b1;
            rd_addr  = rd_idx + IW'(2);
            load_out = 1'b1;
            advance  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      rd_bank       <= 1'b0;
      rd_idx        <= '0;
      m_axis_tvalid <= 1'b0;
      out_data      <= '0;
    end else begin
      state <= state_nxt;
      if (load_out) out_data <= rd_q;
      if (state == PREFETCH) m_axis_tvalid <= 1'b1;
      if (frame_done) begin
        m_axis_tvalid <= 1'b0;
        rd_bank       <= ~rd_bank;
        rd_idx        <= '0;
      end else if (advance) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  assign m_axis_tdata = {16'h0000, out_data};
  assign m_axis_tlast = m_axis_tvalid && (rd_idx == LAST_IDX);

endmodule
